// File: rtl/dct_pkg.sv
// Shared definitions for the 2-D DCT-II datapath: size codes, widths and
// helpers for moving between packed 512-bit vectors and element arrays.
package dct_pkg;

  localparam int W    = 16;
  localparam int NMAX = 32;

  typedef enum logic [1:0] {
    N4  = 2'b00,
    N8  = 2'b01,
    N16 = 2'b10,
    N32 = 2'b11
  } dct_n_e;

  // Element k of a vector lives at index k of this array.
  typedef logic [NMAX-1:0][W-1:0] dct_vec_t;

  function automatic logic [5:0] dct_size(input logic [1:0] n);
    return 6'd4 << n;
  endfunction

  function automatic logic [NMAX-1:0] dct_mask(input logic [1:0] n);
    logic [NMAX-1:0] m;
    for (int k = 0; k < NMAX; k++) m[k] = (6'(k) < dct_size(n));
    return m;
  endfunction

  function automatic dct_vec_t dct_unpack(input logic [0:NMAX*W-1] v);
    dct_vec_t a;
    for (int k = 0; k < NMAX; k++) a[k] = v[k*W +: W];
    return a;
  endfunction

  function automatic logic [0:NMAX*W-1] dct_pack(input dct_vec_t a);
    logic [0:NMAX*W-1] v;
    for (int k = 0; k < NMAX; k++) v[k*W +: W] = a[k];
    return v;
  endfunction

endpackage

// File: rtl/dct2_tpose_mem.sv
// NMAX x NMAX coefficient store: row-wise masked writes, combinational
// column read with rows outside the active size forced to zero.
module dct2_tpose_mem
  import dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [4:0]            wr_row,
  input  logic [0:NMAX*W-1]     wr_data,
  input  logic [NMAX-1:0]       size_mask,
  input  logic [4:0]            rd_col,
  output logic [0:NMAX*W-1]     rd_data
);

  logic [W-1:0] store [NMAX][NMAX];
  dct_vec_t     wr_vec;
  dct_vec_t     col_vec;

  assign wr_vec = dct_unpack(wr_data);

  // Data storage carries no reset; stale contents are never observable
  // because a block is always fully written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NMAX; k++) begin
        if (size_mask[k]) store[wr_row][k] <= wr_vec[k];
      end
    end
  end

  always_comb begin
    col_vec = '0;
    for (int r = 0; r < NMAX; r++) begin
      if (size_mask[r]) col_vec[r] = store[r][rd_col];
    end
  end

  assign rd_data = dct_pack(col_vec);

endmodule

// File: rtl/dct2_transpose_buf.sv
// Transpose buffer between the row and column passes of the 2-D DCT-II:
// fills an SxS block row by row, then drains it column by column.
module dct2_transpose_buf
  import dct_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:511]     in_row,
  input  logic [1:0]       in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:511]     out_col,
  output logic [1:0]       out_n,
  output logic             out_last
);

  localparam logic FILL  = 1'b0;
  localparam logic DRAIN = 1'b1;

  logic             state;
  logic [4:0]       row_cnt;
  logic [4:0]       col_cnt;
  logic [1:0]       blk_n;
  logic [1:0]       cur_n;
  logic [4:0]       last_row;
  logic [4:0]       last_col;
  logic             row_acc;
  logic             col_acc;
  logic [NMAX-1:0]  size_mask;
  logic [0:511]     mem_col;

  // The first row of a block takes its size straight from in_n.
  assign cur_n     = (row_cnt == 5'd0) ? in_n : blk_n;
  assign last_row  = 5'(dct_size(cur_n) - 6'd1);
  assign last_col  = 5'(dct_size(blk_n) - 6'd1);
  assign size_mask = dct_mask((state == DRAIN) ? blk_n : cur_n);

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign row_acc   = in_valid && in_ready;
  assign col_acc   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      row_cnt <= 5'd0;
      col_cnt <= 5'd0;
      blk_n   <= 2'b00;
    end else begin
      case (state)
        FILL: begin
          if (row_acc) begin
            if (row_cnt == 5'd0) blk_n <= in_n;
            if (row_cnt == last_row) begin
              row_cnt <= 5'd0;
              state   <= DRAIN;
            end else begin
              row_cnt <= row_cnt + 5'd1;
            end
          end
        end
        default: begin
          if (col_acc) begin
            if (col_cnt == last_col) begin
              col_cnt <= 5'd0;
              state   <= FILL;
            end else begin
              col_cnt <= col_cnt + 5'd1;
            end
          end
        end
      endcase
    end
  end

  dct2_tpose_mem u_mem (
    .clk       (clk),
    .wr_en     (row_acc),
    .wr_row    (row_cnt),
    .wr_data   (in_row),
    .size_mask (size_mask),
    .rd_col    (col_cnt),
    .rd_data   (mem_col)
  );

  assign out_col  = out_valid ? mem_col : '0;
  assign out_n    = out_valid ? blk_n : 2'b00;
  assign out_last = out_valid && (col_cnt == last_col);

endmodule

// File: tb/tb_dct2_transpose_buf.sv
// Randomized bench for dct2_transpose_buf against a matrix-transpose model.
module tb_dct2_transpose_buf;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:511] in_row;
  logic [1:0]   in_n;
  logic         out_valid;
  logic         out_ready;
  logic [0:511] out_col;
  logic [1:0]   out_n;
  logic         out_last;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [15:0] mdl [32][32];

  always #5 clk = ~clk;

  dct2_transpose_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_n     (out_n),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_model(input int mode);
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < 32; k++) begin
        case (mode)
          0:       mdl[r][k] = 16'(16 * r + k);
          1:       mdl[r][k] = 16'(r * 32 + k);
          3:       mdl[r][k] = ((r + k) % 2 == 0) ? 16'h8000 : 16'h7FFF;
          default: mdl[r][k] = 16'($urandom);
        endcase
      end
    end
  endtask

  function automatic logic [0:511] row_vec(input int r);
    logic [0:511] v;
    for (int k = 0; k < 32; k++) v[16*k +: 16] = mdl[r][k];
    return v;
  endfunction

  // Column c of the stored block: row r contributes mdl[r][c] for r < size.
  function automatic logic [0:511] exp_col(input int c, input int sz);
    logic [0:511] v;
    v = '0;
    for (int r = 0; r < sz; r++) v[16*r +: 16] = mdl[r][c];
    return v;
  endfunction

  task automatic send_rows(input logic [1:0] n0, input logic [1:0] n_mid, input int count);
    int budget;
    for (int r = 0; r < count; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_row   = {16{$urandom}};
        step();
      end
      in_valid = 1'b1;
      in_row   = row_vec(r);
      in_n     = (r == 0) ? n0 : n_mid;
      budget   = 0;
      while (!in_ready && budget < 200) begin
        step();
        budget++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      step();
    end
    in_valid = 1'b0;
    in_row   = {16{$urandom}};
    in_n     = 2'($urandom);
  endtask

  // mode 0: ready every cycle, 1: pattern 1,0,0,1 then random, 2: ready held high
  task automatic drain_block(input logic [1:0] n, input int mode);
    int sz;
    int cyc;
    int budget;
    logic rdy;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    sz  = 4 << n;
    cyc = 0;
    for (int c = 0; c < sz; c++) begin
      budget = 0;
      forever begin
        if (mode == 1) rdy = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
        else rdy = 1'b1;
        cyc++;
        out_ready = rdy;
        chk("out_valid", 512'(out_valid), 512'(1));
        chk("out_col",   512'(out_col), 512'(exp_col(c, sz)));
        chk("out_last",  512'(out_last), 512'(c == sz - 1));
        chk("out_n",     512'(out_n), 512'(n));
        if (rdy) break;
        budget++;
        if (budget > 50) begin
          chk("drain_timeout", 0, 1);
          break;
        end
        step();
      end
      chk("in_ready_drain", 512'(in_ready), 512'(0));
      step();
    end
    if (mode != 2) out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  512'(in_ready), 512'(1));
    chk({tag, "_out_valid"}, 512'(out_valid), 512'(0));
    chk({tag, "_out_col"},   512'(out_col), 512'(0));
    chk({tag, "_out_n"},     512'(out_n), 512'(0));
    chk({tag, "_out_last"},  512'(out_last), 512'(0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_row    = '0;
    in_n      = 2'b00;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_idle("reset");

    // Test 1: smallest block, counting pattern
    fill_model(0);
    send_rows(2'b00, 2'b00, 4);
    drain_block(2'b00, 0);
    chk_idle("t1_after");

    // Test 2: largest block, latency at both ends
    fill_model(1);
    send_rows(2'b11, 2'b11, 32);
    chk("t2_first_valid", 512'(out_valid), 512'(1));
    out_ready = 1'b1;
    drain_block(2'b11, 2);
    chk("t2_in_ready_back", 512'(in_ready), 512'(1));
    chk("t2_valid_drop", 512'(out_valid), 512'(0));
    out_ready = 1'b0;

    // Test 3: stalls on N=8
    fill_model(2);
    send_rows(2'b01, 2'b01, 8);
    drain_block(2'b01, 1);

    // Test 4: 16x16 with in_n wobbling mid-block, then 4x4
    fill_model(2);
    send_rows(2'b10, 2'b11, 16);
    drain_block(2'b10, 0);
    fill_model(2);
    send_rows(2'b00, 2'b11, 4);
    drain_block(2'b00, 1);

    // Test 5: reset mid-fill discards the partial block
    fill_model(2);
    send_rows(2'b01, 2'b01, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("t5_rst");
    fill_model(2);
    send_rows(2'b00, 2'b00, 4);
    drain_block(2'b00, 0);

    // Test 6: extreme signed values pass bit-exact
    fill_model(3);
    send_rows(2'b10, 2'b10, 16);
    drain_block(2'b10, 1);
    chk_idle("t6_after");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
